mem_responder: RTL and testbench

- Memory-side endpoint of the processor↔memory bus that the instruction and data caches initiate on.
- Accepts one BUS_LOAD/BUS_STORE command per cycle and answers combinationally with a 4-bit transaction tag (0 = rejected, retry).
- Completes each accepted transaction exactly MEM_LATENCY cycles later by broadcasting the tag, plus load data, on mem2proc_tag/mem2proc_data.
- Synthesizable behavioural main memory used in simulation and FPGA builds.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Processor<->memory bus. The cache side drives commands and
//               samples the response, tag and data returned by memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Behavioural main memory behind the processor bus. Accepts one
//               load/store per cycle, tags it with the lowest free slot and
//               broadcasts the tag (plus load data) MEM_LATENCY cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int MEM_LATENCY     = 4,
  parameter int MAX_OUTSTANDING = 15,
  parameter int MEM_DWORDS      = 8192
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int         c_AW        = $clog2(MEM_DWORDS);
  localparam logic [1:0] c_BUS_LOAD  = 2'd1;
  localparam logic [1:0] c_BUS_STORE = 2'd2;
  // A slot is selected for completion one cycle before its tag is broadcast,
  // so the countdown runs to zero one cycle earlier than the latency.
  localparam logic [3:0] c_CNT_INIT  = (MEM_LATENCY >= 2) ? 4'(MEM_LATENCY - 2) : 4'd0;
  // With a one-cycle latency the incoming command must be able to complete
  // at the very edge that accepts it.
  localparam bit         c_BYPASS    = (MEM_LATENCY == 1);

  logic [63:0] r_mem [MEM_DWORDS];
  logic [15:1] r_busy;
  logic [3:0]  r_cnt  [16];
  logic [63:0] r_snap [16];
  logic [3:0]  r_tag;
  logic [63:0] r_data;

  logic            w_cmd_valid;
  logic            w_accept;
  logic [3:0]      w_alloc;
  logic [3:0]      w_sel;
  logic [15:1]     w_ready;
  logic [c_AW-1:0] w_word;
  logic [63:0]     w_new_snap;
  logic [63:0]     w_sel_data;
  logic            w_bypass_sel;
  logic            w_unused_addr_bits;

  assign w_word             = bus.proc2mem_addr[c_AW+2:3];
  assign w_unused_addr_bits = ^{bus.proc2mem_addr[31:c_AW+3], bus.proc2mem_addr[2:0]};
  assign w_cmd_valid        = (bus.proc2mem_command == c_BUS_LOAD) ||
                              (bus.proc2mem_command == c_BUS_STORE);
  assign w_new_snap         = (bus.proc2mem_command == c_BUS_LOAD) ? r_mem[w_word] : 64'd0;

  // Lowest free allocatable tag; a tag being broadcast is already free.
  always_comb begin
    w_alloc = 4'd0;
    for (int t = MAX_OUTSTANDING; t >= 1; t--) begin
      if (!r_busy[t]) w_alloc = 4'(t);
    end
  end

  assign w_accept              = w_cmd_valid && !reset && (w_alloc != 4'd0);
  assign bus.mem2proc_response = w_accept ? w_alloc : 4'd0;

  // Pick the lowest-numbered slot ready to complete at the next edge.
  always_comb begin
    w_ready = '0;
    w_sel   = 4'd0;
    for (int t = 1; t <= 15; t++) begin
      w_ready[t] = (r_busy[t] && (r_cnt[t] == 4'd0)) ||
                   (c_BYPASS && w_accept && (w_alloc == 4'(t)));
    end
    for (int t = 15; t >= 1; t--) begin
      if (w_ready[t]) w_sel = 4'(t);
    end
  end

  assign w_bypass_sel = c_BYPASS && w_accept && (w_sel == w_alloc);
  assign w_sel_data   = w_bypass_sel ? w_new_snap : r_snap[w_sel];

  // Slot bookkeeping: allocate, count down, retire and drive the broadcast.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      r_tag  <= 4'd0;
      r_data <= 64'd0;
      for (int t = 0; t < 16; t++) begin
        r_cnt[t]  <= 4'd0;
        r_snap[t] <= 64'd0;
      end
    end else begin
      for (int t = 1; t <= 15; t++) begin
        if (r_busy[t] && (r_cnt[t] != 4'd0)) r_cnt[t] <= r_cnt[t] - 4'd1;
      end
      if (w_accept && !w_bypass_sel) begin
        r_busy[w_alloc] <= 1'b1;
        r_cnt[w_alloc]  <= c_CNT_INIT;
        r_snap[w_alloc] <= w_new_snap;
      end
      if (w_sel != 4'd0) begin
        if (!w_bypass_sel) r_busy[w_sel] <= 1'b0;
        r_tag  <= w_sel;
        r_data <= w_sel_data;
      end else begin
        r_tag  <= 4'd0;
        r_data <= 64'd0;
      end
    end
  end

  // Backing array: stores land at the accepting edge; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_accept && (bus.proc2mem_command == c_BUS_STORE)) r_mem[w_word] <= bus.proc2mem_data;
  end

  assign bus.mem2proc_tag  = r_tag;
  assign bus.mem2proc_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench: directed vector table, tag-exhaustion
//               and mid-flight reset sequences, then randomized traffic
//               against a due-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int c_LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clock = ~clock;

  mem_responder_if bus ();
  mem_responder_if bus3 ();

  mem_responder #(.MEM_LATENCY(c_LAT), .MAX_OUTSTANDING(15), .MEM_DWORDS(8192)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.MEM_LATENCY(c_LAT), .MAX_OUTSTANDING(3), .MEM_DWORDS(8192)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs [18];

  // reference model: absolute broadcast cycle per tag (0 = free)
  int          due  [16];
  logic [63:0] pd   [16];
  logic [63:0] mm   [8192];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    bus.proc2mem_command = c;
    bus.proc2mem_addr    = a;
    bus.proc2mem_data    = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_main(input string name, input logic [3:0] r, input logic [3:0] t, input logic [63:0] d);
    @(negedge clock);
    check({name, "_resp"}, 64'(bus.mem2proc_response), 64'(r));
    check({name, "_tag"},  64'(bus.mem2proc_tag), 64'(t));
    check({name, "_data"}, bus.mem2proc_data, d);
  endtask

  task automatic model_cycle(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    logic [3:0]  et;
    logic [63:0] ed;
    logic [3:0]  er;
    et = 4'd0;
    ed = 64'd0;
    er = 4'd0;
    set_in(c, a, d);
    for (int t = 1; t < 16; t++) begin
      if (due[t] != 0 && due[t] == cyc) begin
        et = 4'(t);
        ed = pd[t];
        due[t] = 0;
      end
    end
    if (c == 2'd1 || c == 2'd2) begin
      for (int t = 15; t >= 1; t--) if (due[t] == 0) er = 4'(t);
    end
    check_main("rand", er, et, ed);
    if (er != 4'd0) begin
      due[er] = cyc + c_LAT;
      pd[er]  = (c == 2'd1) ? mm[a[15:3]] : 64'd0;
      if (c == 2'd2) mm[a[15:3]] = d;
    end
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd2, 32'h0000_0000, 64'h0000_0000_0000_1000, 4'd1, 4'd0, 64'h0};
    vecs[1]  = '{2'd2, 32'h0000_0008, 64'h0000_0000_0000_2000, 4'd2, 4'd0, 64'h0};
    vecs[2]  = '{2'd2, 32'h0000_0010, 64'hDEAD_BEEF_0123_4567, 4'd3, 4'd0, 64'h0};
    vecs[3]  = '{2'd2, 32'h0000_0020, 64'h0000_0000_0000_00A5, 4'd4, 4'd0, 64'h0};
    vecs[4]  = '{2'd1, 32'h0000_0020, 64'h0, 4'd1, 4'd1, 64'h0};
    vecs[5]  = '{2'd1, 32'h0000_0000, 64'h0, 4'd2, 4'd2, 64'h0};
    vecs[6]  = '{2'd1, 32'h0000_0008, 64'h0, 4'd3, 4'd3, 64'h0};
    vecs[7]  = '{2'd1, 32'h0001_0017, 64'h0, 4'd4, 4'd4, 64'h0};
    vecs[8]  = '{2'd0, 32'h0000_0020, 64'h0, 4'd0, 4'd1, 64'h0000_0000_0000_00A5};
    vecs[9]  = '{2'd3, 32'h0000_0008, 64'hFFFF, 4'd0, 4'd2, 64'h0000_0000_0000_1000};
    vecs[10] = '{2'd0, 32'h0000_0008, 64'hEEEE, 4'd0, 4'd3, 64'h0000_0000_0000_2000};
    vecs[11] = '{2'd0, 32'h0000_0010, 64'h0, 4'd0, 4'd4, 64'hDEAD_BEEF_0123_4567};
    vecs[12] = '{2'd1, 32'h0000_0008, 64'h0, 4'd1, 4'd0, 64'h0};
    vecs[13] = '{2'd0, 32'h0000_0000, 64'h0, 4'd0, 4'd0, 64'h0};
    vecs[14] = '{2'd0, 32'h0000_0000, 64'h0, 4'd0, 4'd0, 64'h0};
    vecs[15] = '{2'd0, 32'h0000_0000, 64'h0, 4'd0, 4'd0, 64'h0};
    vecs[16] = '{2'd0, 32'h0000_0000, 64'h0, 4'd0, 4'd1, 64'h0000_0000_0000_2000};
    vecs[17] = '{2'd0, 32'h0000_0000, 64'h0, 4'd0, 4'd0, 64'h0};

    bus3.proc2mem_command = 2'd0;
    bus3.proc2mem_addr    = 32'h0;
    bus3.proc2mem_data    = 64'h0;
    set_in(2'd1, 32'h0, 64'h0);

    // reset state: a command presented during reset is not accepted
    next_cycle();
    next_cycle();
    check_main("reset", 4'd0, 4'd0, 64'h0);
    next_cycle();
    reset = 1'b0;
    set_in(2'd0, 32'h0, 64'h0);

    // directed vector table
    foreach (vecs[i]) begin
      set_in(vecs[i].cmd, vecs[i].addr, vecs[i].data);
      check_main($sformatf("vec%0d", i), vecs[i].resp, vecs[i].tag, vecs[i].rdata);
      next_cycle();
    end
    set_in(2'd0, 32'h0, 64'h0);

    // tag exhaustion with three slots, then retry in the completion cycle
    bus3.proc2mem_command = 2'd1;
    for (int i = 0; i < 4; i++) begin
      bus3.proc2mem_addr = 32'(i * 8);
      @(negedge clock);
      check($sformatf("full_resp%0d", i), 64'(bus3.mem2proc_response), (i < 3) ? 64'(i + 1) : 64'd0);
      check($sformatf("full_tag%0d", i), 64'(bus3.mem2proc_tag), 64'd0);
      next_cycle();
    end
    @(negedge clock);
    check("retry_resp", 64'(bus3.mem2proc_response), 64'd1);
    check("retry_tag", 64'(bus3.mem2proc_tag), 64'd1);
    next_cycle();
    @(negedge clock);
    check("reuse2_resp", 64'(bus3.mem2proc_response), 64'd2);
    check("reuse2_tag", 64'(bus3.mem2proc_tag), 64'd2);
    next_cycle();
    bus3.proc2mem_command = 2'd0;
    for (int i = 0; i < 8; i++) next_cycle();

    // reset with two loads in flight
    set_in(2'd1, 32'h0, 64'h0);
    check_main("inflight0", 4'd1, 4'd0, 64'h0);
    next_cycle();
    set_in(2'd1, 32'h8, 64'h0);
    check_main("inflight1", 4'd2, 4'd0, 64'h0);
    next_cycle();
    reset = 1'b1;
    check_main("midreset", 4'd0, 4'd0, 64'h0);
    next_cycle();
    reset = 1'b0;
    set_in(2'd0, 32'h0, 64'h0);
    for (int i = 0; i < 20; i++) begin
      bus.proc2mem_addr = 32'(i * 8);
      @(negedge clock);
      check($sformatf("postreset_tag%0d", i), 64'(bus.mem2proc_tag), 64'd0);
      next_cycle();
    end
    set_in(2'd1, 32'h0, 64'h0);
    check_main("postreset_load", 4'd1, 4'd0, 64'h0);
    next_cycle();
    set_in(2'd0, 32'h0, 64'h0);
    for (int i = 0; i < c_LAT - 1; i++) next_cycle();
    check_main("postreset_done", 4'd0, 4'd1, 64'h0000_0000_0000_1000);
    next_cycle();

    // randomized traffic against the reference model
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    cyc = 1;
    for (int t = 0; t < 16; t++) due[t] = 0;
    for (int w = 0; w < 32; w++) begin
      model_cycle(2'd2, {$urandom_range(0, 65535), 16'h0} | 32'(w * 8) | 32'($urandom_range(0, 7)),
                  {$urandom, $urandom});
    end
    for (int n = 0; n < 400; n++) begin
      model_cycle(2'($urandom_range(0, 3)),
                  {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 31) * 8) | 32'($urandom_range(0, 7)),
                  {$urandom, $urandom});
    end
    for (int n = 0; n < c_LAT + 2; n++) model_cycle(2'd0, 32'h0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
